// File: rtl/decimal_counter_4d.sv
// Four-digit BCD event counter driven by a same-domain divided tick; wraps at MAX_COUNT.
// Optional down counting is compiled in when COUNT_DOWN_EN is defined.
module decimal_counter_4d #(
  parameter int unsigned MAX_COUNT = 9999
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iTick,
  input  logic        iEnable,
  input  logic        iClear,
  input  logic        iDown,
  output logic [15:0] oBcd,
  output logic        oCarry
);

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_W   = DIGITS * DIGIT_W;

  // Decimal integer to packed BCD, evaluated at elaboration for the wrap value.
  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned n);
    logic [BCD_W-1:0] r;
    int unsigned      v;
    r = '0;
    v = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  // Ripple increment; a digit at 9 (or any out-of-range nibble) rolls to 0 and carries on.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0]   r;
    logic [DIGIT_W-1:0] d;
    logic               cy;
    r  = v;
    cy = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[i*DIGIT_W +: DIGIT_W];
      if (cy) begin
        if (d >= DIGIT_W'(9)) begin
          d = '0;
        end else begin
          d  = d + DIGIT_W'(1);
          cy = 1'b0;
        end
      end
      r[i*DIGIT_W +: DIGIT_W] = d;
    end
    return r;
  endfunction

`ifdef COUNT_DOWN_EN
  // Ripple decrement; a digit at 0 rolls to 9 and borrows from the next one.
  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0]   r;
    logic [DIGIT_W-1:0] d;
    logic               bw;
    r  = v;
    bw = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[i*DIGIT_W +: DIGIT_W];
      if (bw) begin
        if (d == '0) begin
          d = DIGIT_W'(9);
        end else if (d > DIGIT_W'(9)) begin
          d  = DIGIT_W'(9);
          bw = 1'b0;
        end else begin
          d  = d - DIGIT_W'(1);
          bw = 1'b0;
        end
      end
      r[i*DIGIT_W +: DIGIT_W] = d;
    end
    return r;
  endfunction
`else
  logic down_unused;
  assign down_unused = iDown;
`endif

  logic             tick_q, tick_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             carry_q, carry_d;
  logic             tick_evt_c;

  // Next-state: clear beats an enabled event; tick history always follows iTick.
  always_comb begin
    tick_d     = iTick;
    tick_evt_c = iTick & ~tick_q;
    bcd_d      = bcd_q;
    carry_d    = 1'b0;
    if (iClear) begin
      bcd_d = '0;
    end else if (tick_evt_c && iEnable) begin
`ifdef COUNT_DOWN_EN
      if (iDown) begin
        if (bcd_q == '0) begin
          bcd_d   = MAX_BCD;
          carry_d = 1'b1;
        end else begin
          bcd_d = bcd_dec(bcd_q);
        end
      end else
`endif
      begin
        if (bcd_q >= MAX_BCD) begin
          bcd_d   = '0;
          carry_d = 1'b1;
        end else begin
          bcd_d = bcd_inc(bcd_q);
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      tick_q  <= 1'b0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
    end
  end

  assign oBcd   = bcd_q;
  assign oCarry = carry_q;

endmodule

// File: doc/decimal_counter_4d.md
DECIMAL_COUNTER_4D -- requirements
Module: decimal_counter_4d

Interface
REQ-001 The block SHALL have one parameter: MAX_COUNT, default 9999, wrap value as a decimal integer in the range 1..9999.
REQ-002 The block SHALL have port iClk, input, 1 bit: system clock, the same clock that drives the upstream divide-by-50 stage.
REQ-003 The block SHALL have port iRst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port iTick, input, 1 bit: divided clock level from the upstream divider, registered in the iClk domain; each rising edge is one count event.
REQ-005 The block SHALL have port iEnable, input, 1 bit: 1 = count events are applied; 0 = hold.
REQ-006 The block SHALL have port iClear, input, 1 bit: synchronous clear to zero.
REQ-007 The block SHALL have port iDown, input, 1 bit: count direction, 1 = down (honoured only per REQ-024).
REQ-008 The block SHALL have port oBcd, output, 16 bits: four BCD digits; [3:0] = units, [15:12] = thousands.
REQ-009 The block SHALL have port oCarry, output, 1 bit: one-cycle pulse on wrap.

Function
REQ-010 The block SHALL detect events by comparing iTick with a one-register delayed copy (tick_d); event = iTick & ~tick_d; no synchronizer, since iTick is same-domain.
REQ-011 On an event sampled at clock edge N with iEnable=1, oBcd SHALL hold the new value after edge N, giving 1 cycle of latency from iTick rising.
REQ-012 Falling edges of iTick and a constant iTick level SHALL cause no count.
REQ-013 Up count SHALL increment the units digit; a digit at 9 SHALL go to 0 and propagate a carry to the next digit in the same cycle.
REQ-014 Up count with oBcd equal to MAX_COUNT, in BCD, SHALL load 0 and assert oCarry for exactly that one cycle.
REQ-015 Down count SHALL decrement the units digit; a digit at 0 SHALL go to 9 and propagate a borrow in the same cycle.
REQ-016 Down count with oBcd = 0 SHALL load MAX_COUNT in BCD and assert oCarry for one cycle.
REQ-017 Every digit of oBcd SHALL always be in 0..9; a non-BCD nibble SHALL never appear.
REQ-018 Priority SHALL be iClear > event with iEnable=1 > hold; iClear together with an event SHALL yield 0 with oCarry=0.
REQ-019 iClear SHALL NOT reset tick_d, so an event coinciding with iClear is lost and not deferred.
REQ-020 An event with iEnable=0 SHALL be discarded and not queued for later.
REQ-021 oCarry SHALL be 0 in every cycle not described in REQ-014/REQ-016.
REQ-022 If MAX_COUNT < 9999, up counting SHALL never exceed MAX_COUNT.

Reset
REQ-023 While iRst=0, independent of iClk: oBcd=16'h0000, oCarry=0, tick_d=0; on release, a high iTick SHALL count once at the first clock edge, because tick_d=0.

Configuration
REQ-024 The macro COUNT_DOWN_EN SHALL control direction support:
- when defined, iDown selects direction per REQ-015/REQ-016;
- when undefined, iDown is ignored, the block counts up only, the down/borrow logic is not synthesized, and the port list is unchanged.

Verification
REQ-025 Reset, then 10 iTick rising edges with iEnable=1 -> oBcd = 16'h0010; each update 1 cycle after iTick rises; oCarry never asserted.
REQ-026 Preset by counting to 9999, then 1 event -> oBcd = 16'h0000, oCarry = 1 for exactly one cycle; with MAX_COUNT=59: at 0059 plus 1 event -> 0000 with carry.
REQ-027 COUNT_DOWN_EN defined, iDown=1, oBcd=0000, 1 event -> oBcd = 16'h9999 and carry pulse; at 0100 plus 1 event -> 0099. With the macro undefined, iDown=1 and the same stimulus -> 0101.
REQ-028 iTick held high for 200 cycles -> exactly one count; iEnable=0 during 3 events -> oBcd unchanged, and raising iEnable afterwards -> no catch-up counts.
REQ-029 iClear asserted on the same cycle as an event at 0042 -> 0000, oCarry=0. iRst pulled low mid-count (asynchronously, between edges) -> oBcd=0000 immediately; on release with iTick=1 -> 0001 after the first edge.
